tk1_spi_flash_reader: RTL and testbench
=======================================

Name: tk1_spi_flash_reader

Overview:
Sequencer that drives the tk1_spi_master byte interface to perform a complete SPI flash READ transaction: chip select, command byte, 24-bit address, N data bytes, deselect. Delivered bytes appear on a valid/ready stream for firmware DMA or FIFO logic. It sits between tk1 control logic and tk1_spi_master, replacing per-byte firmware polling of the SPI_EN/XFER/DATA registers.

Parameters:
READ_CMD, 8'h03, opcode sent as the first byte.
LEN_WIDTH, 16, width of the byte-count input.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a transaction; sampled only in IDLE
addr  input  24  flash byte address, latched on an accepted start
len  input  LEN_WIDTH  number of data bytes, latched on an accepted start
abort  input  1  level request to terminate early
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle pulse on completion or abort
aborted  output  1  valid with done; 1 if terminated by abort
rd_data  output  8  received data byte
rd_valid  output  1  rd_data valid; held until rd_ready
rd_ready  input  1  consumer accepts rd_data when rd_valid && rd_ready
spi_enable  output  1  to master; 1 = select flash
spi_enable_vld  output  1  to master; one-cycle strobe applying spi_enable
spi_start  output  1  to master; one-cycle strobe starting an 8-bit transfer
spi_tx_data  output  8  to master; byte to send
spi_tx_data_vld  output  1  to master; one-cycle strobe loading spi_tx_data
spi_ready  input  1  from master; 1 = idle or previous byte complete
spi_rx_data  input  8  from master; byte received in the last transfer

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; counters and latches cleared. Reset mid-transaction aborts immediately with no done pulse. tk1_spi_master shares reset_n.
- Master contract: spi_ready falls the cycle after spi_start and rises when the byte completes. spi_rx_data is valid while spi_ready = 1 after completion.
- States:
  IDLE: on start with len != 0, latch addr/len, idx = 0, go SEL. On start with len == 0, done = 1 next cycle (aborted = 0), with no SPI activity.
  SEL: spi_enable = 1, spi_enable_vld = 1; go LOAD.
  LOAD: spi_tx_data = idx 0: READ_CMD; 1: addr[23:16]; 2: addr[15:8]; 3: addr[7:0]; >= 4: 8'h00. spi_tx_data_vld = 1; go XSTART.
  XSTART: spi_start = 1; go WLOW.
  WLOW: unconditional one-cycle wait; go WHIGH.
  WHIGH: wait for spi_ready = 1. If idx < 4: idx++, go LOAD. Otherwise capture spi_rx_data into rd_data, assert rd_valid, go OUT.
  OUT: hold until rd_valid && rd_ready; then deassert rd_valid and decrement the remaining count. If the remaining count reaches 0, go DESEL; else go LOAD.
  DESEL: spi_enable = 0, spi_enable_vld = 1; go DONE.
  DONE: done = 1 for one cycle; busy = 0 from this cycle; go IDLE.
- Byte index saturates at 4 and does not wrap. The remaining count is LEN_WIDTH bits wide, so the maximum length is 2^LEN_WIDTH - 1.
- Backpressure: the next byte transfer never starts until the current byte is consumed, so SCK stalls and no byte is lost.
- Abort:
  - In SEL, LOAD or OUT: go DESEL and drop rd_valid.
  - In XSTART, WLOW or WHIGH: finish the byte in flight (await spi_ready), discard its data, then go DESEL.
  - In DONE the abort is ignored. aborted = 1 with the resulting done.
- start while busy is ignored. The start and done pulses never overlap for the same transaction.
- Latency: an accepted start gives spi_enable_vld 1 cycle later and the first spi_start 3 cycles later. Minimum per-byte overhead is 4 cycles plus the master transfer time.

Decomposition:
- Package tk1_spi_flash_pkg: state encoding constants, READ_CMD default, HDR_BYTES = 4.
- Single module; no sub-module needed. The flash reader is instantiated alongside tk1_spi_master.

Test Plan:
- Read len=3 from addr=24'h012345; model returns AA,BB,CC; rd_ready=1 -> MOSI bytes 03,01,23,45,00,00,00. rd_data sequence AA,BB,CC. Exactly one done pulse with aborted=0. spi_enable pulses 1 then 0.
- len=0 with start -> done the next cycle; no spi_* strobes; busy stays 0.
- len=2, rd_ready held 0 for 50 cycles after the first byte -> rd_valid and rd_data=first byte held stable, no spi_start during the stall, second byte follows after release.
- abort raised in WHIGH of data byte 1 of len=4 -> in-flight byte completes, no rd_valid for it, deselect, done with aborted=1, only 5 spi_start strobes total.
- start asserted again while busy -> ignored; addr/len unchanged; single done.
- reset_n low mid-address-byte -> all outputs 0 asynchronously, state IDLE. A new start afterwards completes normally.

Source files
------------

// File: rtl/tk1_spi_flash_pkg.sv
// Shared definitions for the SPI flash READ sequencer: state encoding,
// default opcode and the header-byte selector.
package tk1_spi_flash_pkg;

  localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;
  localparam int         HDR_BYTES        = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SEL    = 4'd1,
    ST_LOAD   = 4'd2,
    ST_XSTART = 4'd3,
    ST_WLOW   = 4'd4,
    ST_WHIGH  = 4'd5,
    ST_OUT    = 4'd6,
    ST_DESEL  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  // Header is opcode then address MSB first; every later byte is a dummy 00.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  cmd,
                                          input logic [23:0] a);
    logic [7:0] b;
    case (idx)
      3'd0:    b = cmd;
      3'd1:    b = a[23:16];
      3'd2:    b = a[15:8];
      3'd3:    b = a[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tk1_spi_flash_reader.sv
// Drives tk1_spi_master through a full flash READ (select, opcode, 24-bit
// address, N data bytes, deselect) and streams the data bytes out valid/ready.
//
// state  | meaning
// IDLE   | waiting for start
// SEL    | assert chip select
// LOAD   | present next byte to the master
// XSTART | strobe the 8-bit transfer
// WLOW   | let the master drop spi_ready
// WHIGH  | wait for the byte to complete
// OUT    | hold received byte until consumed
// DESEL  | release chip select
// DONE   | completion pulse
module tk1_spi_flash_reader
  import tk1_spi_flash_pkg::*;
#(
  parameter logic [7:0] READ_CMD  = READ_CMD_DEFAULT,
  parameter int         LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [23:0]          addr,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 spi_enable,
  output logic                 spi_enable_vld,
  output logic                 spi_start,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_tx_data_vld,
  input  logic                 spi_ready,
  input  logic [7:0]           spi_rx_data
);

  state_t               state, state_nx;
  logic [23:0]          addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [2:0]           idx_q;
  logic                 abort_q;
  logic [7:0]           rd_data_q;

  logic in_hdr;
  logic stop_req;
  logic active;

  assign in_hdr   = (idx_q < 3'(HDR_BYTES));
  assign stop_req = abort | abort_q;
  assign active   = (state == ST_SEL)   || (state == ST_LOAD) ||
                    (state == ST_XSTART) || (state == ST_WLOW) ||
                    (state == ST_WHIGH)  || (state == ST_OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = (len == '0) ? ST_DONE : ST_SEL;
      ST_SEL:    state_nx = abort ? ST_DESEL : ST_LOAD;
      ST_LOAD:   state_nx = abort ? ST_DESEL : ST_XSTART;
      ST_XSTART: state_nx = ST_WLOW;
      ST_WLOW:   state_nx = ST_WHIGH;
      ST_WHIGH: begin
        // A byte in flight is always allowed to finish before deselecting.
        if (spi_ready) begin
          if (stop_req)    state_nx = ST_DESEL;
          else if (in_hdr) state_nx = ST_LOAD;
          else             state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        if (abort)         state_nx = ST_DESEL;
        else if (rd_ready) state_nx = (rem_q == LEN_WIDTH'(1)) ? ST_DESEL : ST_LOAD;
      end
      ST_DESEL:  state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      abort_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (state == ST_IDLE) begin
        abort_q <= 1'b0;
        if (start && (len != '0)) begin
          addr_q <= addr;
          rem_q  <= len;
          idx_q  <= '0;
        end
      end else if (active && abort) begin
        abort_q <= 1'b1;
      end

      if ((state == ST_WHIGH) && spi_ready && !stop_req) begin
        if (in_hdr) idx_q     <= idx_q + 3'd1;
        else        rd_data_q <= spi_rx_data;
      end

      if ((state == ST_OUT) && rd_ready && !abort)
        rem_q <= rem_q - LEN_WIDTH'(1);
    end
  end

  assign busy            = (state != ST_IDLE) && (state != ST_DONE);
  assign done            = (state == ST_DONE);
  assign aborted         = (state == ST_DONE) && abort_q;
  assign rd_valid        = (state == ST_OUT);
  assign rd_data         = rd_data_q;
  assign spi_enable      = active;
  assign spi_enable_vld  = (state == ST_SEL) || (state == ST_DESEL);
  assign spi_start       = (state == ST_XSTART);
  assign spi_tx_data_vld = (state == ST_LOAD);
  assign spi_tx_data     = (state == ST_LOAD) ? hdr_byte(idx_q, READ_CMD, addr_q) : 8'h00;

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Scoreboard bench: a behavioural flash behind a tk1_spi_master-like model,
// expected data computed from the flash contents at the requested address.
module tb_tk1_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] addr;
  logic [15:0] len;
  logic        abort;
  logic        busy, done, aborted;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        spi_enable, spi_enable_vld, spi_start, spi_tx_data_vld;
  logic [7:0]  spi_tx_data;
  logic        spi_ready;
  logic [7:0]  spi_rx_data;

  always #5 clk = ~clk;

  tk1_spi_flash_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .spi_enable(spi_enable), .spi_enable_vld(spi_enable_vld),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_tx_data_vld(spi_tx_data_vld), .spi_ready(spi_ready),
    .spi_rx_data(spi_rx_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_start, n_envld, n_done, n_busy, n_consumed;
  logic [7:0] mosi_q[$];
  logic [7:0] exp_q[$];
  bit   ready_hold0 = 0;
  bit   ready_rand  = 0;
  int unsigned lat_min = 2, lat_max = 5;
  bit   stall_prev = 0;
  logic [7:0] stall_data = 8'h00;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Flash + SPI master model: decodes the address from MOSI, returns data.
  int          m_cnt;
  int          m_nbytes;
  logic [7:0]  m_txbuf, m_pend;
  logic [23:0] m_faddr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_ready <= 1'b1; spi_rx_data <= 8'h00; m_cnt <= 0; m_nbytes <= 0;
      m_txbuf <= 8'h00; m_pend <= 8'h00; m_faddr <= 24'h0;
    end else begin
      if (spi_enable_vld) m_nbytes <= 0;
      if (spi_tx_data_vld) m_txbuf <= spi_tx_data;
      if (spi_start) begin
        spi_ready <= 1'b0;
        m_cnt     <= int'($urandom_range(lat_max, lat_min));
        if (m_nbytes < 4) begin
          m_pend <= 8'hFF;
          if (m_nbytes > 0) m_faddr <= {m_faddr[15:0], m_txbuf};
        end else begin
          m_pend <= flash_byte(m_faddr + 24'(m_nbytes - 4));
        end
        m_nbytes <= m_nbytes + 1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          spi_ready   <= 1'b1;
          spi_rx_data <= m_pend;
        end
      end
    end
  end

  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_hold0)     rd_ready = 1'b0;
      else if (ready_rand) rd_ready = ($urandom_range(0, 3) != 0);
      else                 rd_ready = 1'b1;
    end
  end

  // Monitor: counts strobes, checks stall stability and pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (spi_start)       n_start++;
      if (spi_enable_vld)  n_envld++;
      if (done)            n_done++;
      if (busy)            n_busy++;
      if (spi_tx_data_vld) mosi_q.push_back(spi_tx_data);
      if (rd_valid) chk("no_spi_start_while_valid", {31'd0, spi_start}, 32'd0);
      if (stall_prev) begin
        chk("stall_valid_held", {31'd0, rd_valid}, 32'd1);
        chk("stall_data_held", {24'd0, rd_data}, {24'd0, stall_data});
      end
      if (rd_valid && rd_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_unexpected: got byte %h, expected no byte", rd_data);
        end else begin
          chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
      stall_prev = rd_valid && !rd_ready;
      stall_data = rd_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic start_txn(input logic [23:0] a, input logic [15:0] l, input bit push);
    n_start = 0; n_envld = 0; n_done = 0; n_busy = 0; n_consumed = 0;
    mosi_q.delete();
    if (push) for (int k = 0; k < int'(l); k++) exp_q.push_back(flash_byte(a + 24'(k)));
    @(posedge clk); #1;
    addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr = 24'($urandom); len = 16'($urandom);
  endtask

  task automatic wait_done(output logic ab, output logic bz);
    bit seen = 0;
    ab = 1'b0; bz = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin ab = aborted; bz = busy; seen = 1; end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done, expected one within 20000 cycles");
    end
  endtask

  task automatic wait_starts(input int n);
    bit seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      if (n_start >= n) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL start_timeout: got %0d spi_start, expected %0d", n_start, n);
    end
  endtask

  task automatic check_end(input logic [23:0] a, input int nstarts, input logic exp_ab,
                           input int nbytes, input logic ab, input logic bz);
    logic [7:0] e;
    chk("aborted_at_done", {31'd0, ab}, {31'd0, exp_ab});
    chk("busy_at_done", {31'd0, bz}, 32'd0);
    repeat (3) @(negedge clk);
    chk("done_pulses", n_done, 1);
    chk("spi_start_count", n_start, nstarts);
    chk("spi_enable_vld_count", n_envld, 2);
    chk("mosi_count", mosi_q.size(), nstarts);
    for (int i = 0; i < nstarts && i < mosi_q.size(); i++) begin
      case (i)
        0:       e = 8'h03;
        1:       e = a[23:16];
        2:       e = a[15:8];
        3:       e = a[7:0];
        default: e = 8'h00;
      endcase
      chk("mosi_byte", {24'd0, mosi_q[i]}, {24'd0, e});
    end
    chk("bytes_consumed", n_consumed, nbytes);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("spi_enable_idle", {31'd0, spi_enable}, 32'd0);
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [15:0] l);
    logic ab, bz;
    start_txn(a, l, 1);
    wait_done(ab, bz);
    check_end(a, 4 + int'(l), 1'b0, int'(l), ab, bz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ab, bz;
    reset_n = 1'b0; start = 1'b0; addr = 24'h0; len = 16'h0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_outputs", {8'd0, busy, done, aborted, rd_valid, rd_data, spi_enable,
        spi_enable_vld, spi_start, spi_tx_data, spi_tx_data_vld}, 32'd0);
    reset_n = 1'b1;

    // Basic read
    run_txn(24'h012345, 16'd3);

    // Zero length: done next cycle, no SPI activity, never busy
    start_txn(24'h00ABCD, 16'd0, 1);
    @(negedge clk);
    chk("len0_done_next_cycle", {31'd0, done}, 32'd1);
    chk("len0_aborted", {31'd0, aborted}, 32'd0);
    repeat (3) @(negedge clk);
    chk("len0_done_pulses", n_done, 1);
    chk("len0_busy_cycles", n_busy, 0);
    chk("len0_spi_start", n_start, 0);
    chk("len0_spi_envld", n_envld, 0);
    chk("len0_mosi", mosi_q.size(), 0);

    // Backpressure stall of 50 cycles on the first byte
    ready_hold0 = 1;
    start_txn(24'h3C0FF0, 16'd2, 1);
    begin
      bit seen = 0;
      for (int k = 0; k < 2000 && !seen; k++) begin
        @(negedge clk);
        if (rd_valid) seen = 1;
      end
      chk("stall_first_valid_seen", {31'd0, seen}, 32'd1);
    end
    repeat (50) @(posedge clk);
    chk("stall_starts_held", n_start, 5);
    chk("stall_nothing_consumed", n_consumed, 0);
    ready_hold0 = 0;
    wait_done(ab, bz);
    check_end(24'h3C0FF0, 6, 1'b0, 2, ab, bz);

    // Abort while waiting on the first data byte
    lat_min = 6; lat_max = 6;
    start_txn(24'h5A5A5A, 16'd4, 0);
    wait_starts(5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    wait_done(ab, bz);
    abort = 1'b0;
    check_end(24'h5A5A5A, 5, 1'b1, 0, ab, bz);
    lat_min = 2; lat_max = 5;

    // Start while busy is ignored
    start_txn(24'h1357AC, 16'd3, 1);
    repeat (6) @(posedge clk);
    #1; addr = 24'hDEAD00; len = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(ab, bz);
    check_end(24'h1357AC, 7, 1'b0, 3, ab, bz);

    // Async reset during an address byte, then a clean transaction
    start_txn(24'hABCDEF, 16'd3, 1);
    wait_starts(2);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {8'd0, busy, done, aborted, rd_valid, rd_data, spi_enable,
        spi_enable_vld, spi_start, spi_tx_data, spi_tx_data_vld}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    run_txn(24'h000102, 16'd2);

    // Address wrap at the top of the flash, then randomized traffic
    run_txn(24'hFFFFFE, 16'd4);
    ready_rand = 1;
    for (int t = 0; t < 10; t++) begin
      lat_min = 2; lat_max = $urandom_range(2, 6);
      run_txn(24'($urandom), 16'($urandom_range(1, 6)));
    end
    ready_rand = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
